// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and counter-width helper for the zone alarm
package alarm_pkg;

   typedef enum logic [2:0] {
      DISARMED    = 3'd0,
      EXIT_DELAY  = 3'd1,
      ARMED       = 3'd2,
      ENTRY_DELAY = 3'd3,
      TRIGGERED   = 3'd4
   } alarm_state_e;

   // Never returns less than one bit, so an all-zero delay set still elaborates.
   function automatic int cnt_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - loadable down-counter shared by the exit, entry and siren delays
module alarm_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// rtl/alarm_zone_ctrl.sv - multi-zone alarm with exit/entry delays, siren timeout,
// sticky zone latch and a saturating trigger counter
module alarm_zone_ctrl
   import alarm_pkg::*;
#(
   parameter int                N_ZONES      = 4,
   parameter logic [N_ZONES-1:0] INSTANT_MASK = '0,
   parameter int                EXIT_CYCLES  = 16,
   parameter int                ENTRY_CYCLES = 8,
   parameter int                SIREN_CYCLES = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               arm,
   input  logic               disarm,
   input  logic [N_ZONES-1:0] trigger,
   input  logic [N_ZONES-1:0] zone_en,
   output logic               disarmed,
   output logic               exit_pending,
   output logic               armed,
   output logic               entry_pending,
   output logic               triggered,
   output logic               siren,
   output logic [N_ZONES-1:0] zone_latch,
   output logic [7:0]         trig_count
);

   localparam int MAX_A  = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
   localparam int MAX_C  = (MAX_A > SIREN_CYCLES) ? MAX_A : SIREN_CYCLES;
   localparam int TW     = cnt_w(MAX_C);
   localparam logic [TW-1:0] EXIT_LOAD  = TW'((EXIT_CYCLES  > 0) ? EXIT_CYCLES  - 1 : 0);
   localparam logic [TW-1:0] ENTRY_LOAD = TW'((ENTRY_CYCLES > 0) ? ENTRY_CYCLES - 1 : 0);
   localparam logic [TW-1:0] SIREN_LOAD = TW'((SIREN_CYCLES > 0) ? SIREN_CYCLES - 1 : 0);

   if (SIREN_CYCLES < 1) begin : g_bad_siren
      $error("alarm_zone_ctrl: SIREN_CYCLES must be >= 1");
   end
   if ((N_ZONES < 1) || (N_ZONES > 16)) begin : g_bad_zones
      $error("alarm_zone_ctrl: N_ZONES must be 1..16");
   end

   alarm_state_e       state_q, state_d;
   logic               siren_q, siren_d;
   logic [N_ZONES-1:0] latch_q, latch_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               t_load, t_tick, t_zero;
   logic [TW-1:0]      t_load_val;
   logic [N_ZONES-1:0] hit, inst;

   assign hit  = trigger & zone_en;
   // With no entry delay every enabled zone behaves as an instant zone.
   assign inst = (ENTRY_CYCLES == 0) ? hit : (hit & INSTANT_MASK);

   alarm_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (t_load),
      .load_val (t_load_val),
      .tick     (t_tick),
      .zero     (t_zero)
   );

   always_comb begin
      state_d    = state_q;
      siren_d    = siren_q;
      latch_d    = latch_q;
      cnt_d      = cnt_q;
      t_load     = 1'b0;
      t_load_val = '0;
      t_tick     = 1'b0;

      if (disarm) begin
         state_d = DISARMED;
         siren_d = 1'b0;
      end else begin
         unique case (state_q)
            DISARMED: begin
               if (arm) begin
                  latch_d = '0;
                  if (EXIT_CYCLES == 0) begin
                     state_d = ARMED;
                  end else begin
                     state_d    = EXIT_DELAY;
                     t_load     = 1'b1;
                     t_load_val = EXIT_LOAD;
                  end
               end
            end
            EXIT_DELAY: begin
               if (t_zero) state_d = ARMED;
               else        t_tick  = 1'b1;
            end
            ARMED: begin
               latch_d = latch_q | hit;
               if (|inst) begin
                  state_d    = TRIGGERED;
                  siren_d    = 1'b1;
                  t_load     = 1'b1;
                  t_load_val = SIREN_LOAD;
                  cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               end else if (|hit) begin
                  state_d    = ENTRY_DELAY;
                  t_load     = 1'b1;
                  t_load_val = ENTRY_LOAD;
               end
            end
            ENTRY_DELAY: begin
               latch_d = latch_q | hit;
               if ((|inst) || t_zero) begin
                  state_d    = TRIGGERED;
                  siren_d    = 1'b1;
                  t_load     = 1'b1;
                  t_load_val = SIREN_LOAD;
                  cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               end else begin
                  t_tick = 1'b1;
               end
            end
            TRIGGERED: begin
               latch_d = latch_q | hit;
               if (t_zero) siren_d = 1'b0;
               else        t_tick  = 1'b1;
            end
            default: begin
               state_d = DISARMED;
               siren_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DISARMED;
         siren_q <= 1'b0;
         latch_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         siren_q <= siren_d;
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
      end
   end

   assign disarmed      = (state_q == DISARMED);
   assign exit_pending  = (state_q == EXIT_DELAY);
   assign armed         = (state_q == ARMED);
   assign entry_pending = (state_q == ENTRY_DELAY);
   assign triggered     = (state_q == TRIGGERED);
   assign siren         = siren_q;
   assign zone_latch    = latch_q;
   assign trig_count    = cnt_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb/tb_alarm_zone_ctrl.sv - directed self-checking bench for alarm_zone_ctrl
module tb_alarm_zone_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;

   logic       a_arm, a_disarm;
   logic [3:0] a_trig, a_en;
   logic       a_dis, a_exit, a_armed, a_entry, a_trg, a_siren;
   logic [3:0] a_latch;
   logic [7:0] a_cnt;

   logic       b_arm, b_disarm;
   logic [3:0] b_trig, b_en;
   logic       b_dis, b_exit, b_armed, b_entry, b_trg, b_siren;
   logic [3:0] b_latch;
   logic [7:0] b_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alarm_zone_ctrl u_dut_a (
      .clk(clk), .reset_n(reset_n), .arm(a_arm), .disarm(a_disarm),
      .trigger(a_trig), .zone_en(a_en),
      .disarmed(a_dis), .exit_pending(a_exit), .armed(a_armed),
      .entry_pending(a_entry), .triggered(a_trg), .siren(a_siren),
      .zone_latch(a_latch), .trig_count(a_cnt)
   );

   alarm_zone_ctrl #(.INSTANT_MASK(4'b1000), .EXIT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .arm(b_arm), .disarm(b_disarm),
      .trigger(b_trig), .zone_en(b_en),
      .disarmed(b_dis), .exit_pending(b_exit), .armed(b_armed),
      .entry_pending(b_entry), .triggered(b_trg), .siren(b_siren),
      .zone_latch(b_latch), .trig_count(b_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] st_a();
      return {a_dis, a_exit, a_armed, a_entry, a_trg};
   endfunction

   function automatic logic [4:0] st_b();
      return {b_dis, b_exit, b_armed, b_entry, b_trg};
   endfunction

   localparam logic [4:0] S_DIS = 5'b10000, S_EXIT = 5'b01000, S_ARM = 5'b00100,
                          S_ENT = 5'b00010, S_TRG = 5'b00001;

   initial begin
      reset_n = 1'b0;
      a_arm = 0; a_disarm = 0; a_trig = 4'h0; a_en = 4'hF;
      b_arm = 0; b_disarm = 0; b_trig = 4'h0; b_en = 4'hF;
      step(); step();
      reset_n = 1'b1;
      step();

      chk("a_reset_state", 32'(st_a()), 32'(S_DIS));
      chk("a_reset_siren", 32'(a_siren), 32'd0);
      chk("a_reset_latch", 32'(a_latch), 32'd0);
      chk("a_reset_cnt",   32'(a_cnt),   32'd0);
      chk("b_reset_state", 32'(st_b()), 32'(S_DIS));

      // exit delay of 16 cycles, triggers ignored meanwhile
      a_arm = 1; step(); a_arm = 0;
      a_trig = 4'hF;
      chk("a_exit_first", 32'(st_a()), 32'(S_EXIT));
      repeat (15) step();
      chk("a_exit_last", 32'(st_a()), 32'(S_EXIT));
      step();
      a_trig = 4'h0;
      chk("a_armed_after_exit", 32'(st_a()), 32'(S_ARM));
      chk("a_latch_exit_ignored", 32'(a_latch), 32'd0);

      // disabled zone is ignored
      a_en = 4'b1110; a_trig = 4'b0001;
      repeat (3) step();
      chk("a_disabled_zone_state", 32'(st_a()), 32'(S_ARM));
      chk("a_disabled_zone_latch", 32'(a_latch), 32'd0);
      a_trig = 4'h0; a_en = 4'hF;

      // delayed zone: 8 entry cycles then 32 siren cycles
      a_trig = 4'b0010; step(); a_trig = 4'h0;
      chk("a_entry_first", 32'(st_a()), 32'(S_ENT));
      repeat (7) step();
      chk("a_entry_last", 32'(st_a()), 32'(S_ENT));
      step();
      chk("a_trig_state", 32'(st_a()), 32'(S_TRG));
      chk("a_siren_on", 32'(a_siren), 32'd1);
      chk("a_cnt_one", 32'(a_cnt), 32'd1);
      repeat (31) step();
      chk("a_siren_last", 32'(a_siren), 32'd1);
      step();
      chk("a_siren_off", 32'(a_siren), 32'd0);
      chk("a_still_trig", 32'(st_a()), 32'(S_TRG));
      chk("a_latch_z1", 32'(a_latch), 32'b0010);

      // re-arm, trip again, then arm+disarm together mid-siren
      a_disarm = 1; step(); a_disarm = 0;
      a_arm = 1; step(); a_arm = 0;
      chk("a_rearm_latch_clr", 32'(a_latch), 32'd0);
      repeat (16) step();
      a_trig = 4'b0100; step(); a_trig = 4'h0;
      repeat (8) step();
      chk("a_trig2_siren", 32'(a_siren), 32'd1);
      chk("a_cnt_two", 32'(a_cnt), 32'd2);
      a_arm = 1; a_disarm = 1; step(); a_arm = 0; a_disarm = 0;
      chk("a_armdis_state", 32'(st_a()), 32'(S_DIS));
      chk("a_armdis_siren", 32'(a_siren), 32'd0);
      chk("a_armdis_latch_kept", 32'(a_latch), 32'b0100);
      chk("a_armdis_cnt_kept", 32'(a_cnt), 32'd2);

      // instant zone cuts an entry delay short; EXIT_CYCLES=0 arms directly
      b_arm = 1; step(); b_arm = 0;
      chk("b_armed_direct", 32'(st_b()), 32'(S_ARM));
      b_trig = 4'b0001; step(); b_trig = 4'h0;
      chk("b_entry", 32'(st_b()), 32'(S_ENT));
      step(); step();
      b_trig = 4'b1000; step(); b_trig = 4'h0;
      chk("b_instant_trig", 32'(st_b()), 32'(S_TRG));
      chk("b_latch_1001", 32'(b_latch), 32'b1001);
      chk("b_cnt_one", 32'(b_cnt), 32'd1);

      // saturation of the trigger counter
      for (int i = 0; i < 300; i++) begin
         b_disarm = 1; step(); b_disarm = 0;
         b_arm = 1; step(); b_arm = 0;
         b_trig = 4'b1000; step(); b_trig = 4'h0;
         if (i == 99) chk("b_cnt_101", 32'(b_cnt), 32'd101);
         if (i == 253) chk("b_cnt_255", 32'(b_cnt), 32'd255);
      end
      chk("b_cnt_saturated", 32'(b_cnt), 32'd255);
      chk("b_loop_siren", 32'(b_siren), 32'd1);

      // asynchronous reset mid-siren
      reset_n = 1'b0;
      #1;
      chk("b_rst_state", 32'(st_b()), 32'(S_DIS));
      chk("b_rst_siren", 32'(b_siren), 32'd0);
      chk("b_rst_latch", 32'(b_latch), 32'd0);
      chk("b_rst_cnt",   32'(b_cnt),   32'd0);
      chk("a_rst_cnt",   32'(a_cnt),   32'd0);
      step();
      reset_n = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
